// File: rtl/arm_inst_encoder.sv
// ARM instruction word builder: field bundle in, 32-bit encoding out through a
// two-stage valid/ready pipeline with illegal-request dropping and saturating counters.
module arm_inst_encoder #(
    parameter int CNT_W = 16,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_class,
    input  logic [2:0]       in_dtype,
    input  logic [3:0]       in_cond,
    input  logic [3:0]       in_opcode,
    input  logic             in_s,
    input  logic [3:0]       in_rn,
    input  logic [3:0]       in_rd,
    input  logic [11:0]      in_op2,
    input  logic [25:0]      in_raw,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_inst,
    output logic             err_pulse,
    output logic [CNT_W-1:0] inst_count,
    output logic [ERR_W-1:0] err_count
);

    logic             a_valid_q, a_valid_d;
    logic             a_ill_q, a_ill_d;
    logic [31:0]      a_word_q, a_word_d;
    logic             out_valid_q, out_valid_d;
    logic [31:0]      out_inst_q, out_inst_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] inst_count_q, inst_count_d;
    logic [ERR_W-1:0] err_count_q, err_count_d;

    logic [31:0] enc_word;
    logic        enc_ill;
    logic        b_ready, a_fire, a_adv;

    // Encoding is done at capture so stage A already holds the final word.
    always_comb begin
        enc_ill  = 1'b0;
        enc_word = {in_cond, 2'b11, in_raw};
        case (in_class)
            2'd0: enc_word = {in_cond, 2'b11, in_raw};
            2'd2: enc_word = {in_cond, 2'b01, in_raw};
            2'd3: enc_word = {in_cond, 2'b10, in_raw};
            default: begin
                case (in_dtype)
                    3'd1: enc_word = {in_cond, 2'b00, 1'b1, in_opcode, in_s, in_rn, in_rd, in_op2};
                    3'd2: enc_word = {in_cond, 3'b000, in_opcode, in_s, in_rn, in_rd,
                                      in_op2[11:5], 1'b0, in_op2[3:0]};
                    3'd3: enc_word = {in_cond, 3'b000, in_opcode, in_s, in_rn, in_rd,
                                      in_op2[11:8], 1'b0, in_op2[6:5], 1'b1, in_op2[3:0]};
                    3'd4: enc_word = {in_cond, 6'b000000, in_opcode[0], in_s, in_rn, in_rd,
                                      in_op2[11:8], 4'b1001, in_op2[3:0]};
                    default: enc_ill = 1'b1;
                endcase
            end
        endcase
    end

    always_comb begin
        b_ready  = !out_valid_q || out_ready;
        in_ready = !a_valid_q || b_ready;
        a_fire   = in_valid && in_ready;
        a_adv    = a_valid_q && b_ready;

        a_valid_d = a_fire ? 1'b1 : (a_adv ? 1'b0 : a_valid_q);
        a_word_d  = a_fire ? enc_word : a_word_q;
        a_ill_d   = a_fire ? enc_ill : a_ill_q;

        // An illegal word leaving stage A becomes an empty slot in stage B.
        out_valid_d = b_ready ? (a_valid_q && !a_ill_q) : out_valid_q;
        out_inst_d  = (a_adv && !a_ill_q) ? a_word_q : out_inst_q;
        err_pulse_d = a_adv && a_ill_q;

        inst_count_d = inst_count_q;
        if (out_valid_q && out_ready && inst_count_q != {CNT_W{1'b1}})
            inst_count_d = inst_count_q + CNT_W'(1);
        err_count_d = err_count_q;
        if (a_adv && a_ill_q && err_count_q != {ERR_W{1'b1}})
            err_count_d = err_count_q + ERR_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid_q    <= 1'b0;
            a_ill_q      <= 1'b0;
            a_word_q     <= '0;
            out_valid_q  <= 1'b0;
            out_inst_q   <= '0;
            err_pulse_q  <= 1'b0;
            inst_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_ill_q      <= a_ill_d;
            a_word_q     <= a_word_d;
            out_valid_q  <= out_valid_d;
            out_inst_q   <= out_inst_d;
            err_pulse_q  <= err_pulse_d;
            inst_count_q <= inst_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_inst   = out_inst_q;
    assign err_pulse  = err_pulse_q;
    assign inst_count = inst_count_q;
    assign err_count  = err_count_q;

endmodule

// File: tb/tb_arm_inst_encoder.sv
// Bench for arm_inst_encoder: directed cases plus randomized requests scored
// against an arithmetic encoding model and an expected-word queue.
module tb_arm_inst_encoder;

    typedef struct {
        logic [1:0]  cls;
        logic [2:0]  dt;
        logic [3:0]  cond;
        logic [3:0]  opc;
        logic        s;
        logic [3:0]  rn;
        logic [3:0]  rd;
        logic [11:0] op2;
        logic [25:0] raw;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_class = '0;
    logic [2:0]  in_dtype = '0;
    logic [3:0]  in_cond = '0;
    logic [3:0]  in_opcode = '0;
    logic        in_s = 1'b0;
    logic [3:0]  in_rn = '0;
    logic [3:0]  in_rd = '0;
    logic [11:0] in_op2 = '0;
    logic [25:0] in_raw = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_inst;
    logic        err_pulse;
    logic [15:0] inst_count;
    logic [7:0]  err_count;

    arm_inst_encoder #(.CNT_W(16), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_dtype(in_dtype), .in_cond(in_cond),
        .in_opcode(in_opcode), .in_s(in_s), .in_rn(in_rn), .in_rd(in_rd),
        .in_op2(in_op2), .in_raw(in_raw),
        .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .err_pulse(err_pulse), .inst_count(inst_count), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int hs_cnt = 0;
    int pulse_cnt = 0;
    int err_acc = 0;
    int err_exp = 0;
    bit rand_mode = 1'b0;
    logic [31:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoding: place each field at its bit position by arithmetic.
    function automatic logic [32:0] model_enc(req_t r);
        logic [31:0] w;
        logic [31:0] base;
        logic [31:0] op2;
        logic [31:0] top;
        op2  = 32'(r.op2);
        base = (32'(r.cond) << 28) | (32'(r.s) << 20) | (32'(r.rn) << 16) | (32'(r.rd) << 12);
        if (r.cls != 2'd1) begin
            top = (r.cls == 2'd0) ? 32'd3 : (r.cls == 2'd2) ? 32'd1 : 32'd2;
            w = (32'(r.cond) << 28) | (top << 26) | 32'(r.raw);
            return {1'b0, w};
        end
        case (r.dt)
            3'd1: w = base | (32'd1 << 25) | (32'(r.opc) << 21) | op2;
            3'd2: w = base | (32'(r.opc) << 21) | (op2 & 32'hFEF);
            3'd3: w = base | (32'(r.opc) << 21) | (op2 & 32'hF6F) | 32'h10;
            3'd4: w = base | (32'(r.opc & 4'd1) << 21) | (op2 & 32'hF0F) | 32'h90;
            default: return {1'b1, 32'h0};
        endcase
        return {1'b0, w};
    endfunction

    // Holds the request until accepted, then returns at the following negedge.
    task automatic send(input req_t r);
        logic [32:0] m;
        int waited;
        in_valid = 1'b1;
        in_class = r.cls; in_dtype = r.dt; in_cond = r.cond; in_opcode = r.opc;
        in_s = r.s; in_rn = r.rn; in_rd = r.rd; in_op2 = r.op2; in_raw = r.raw;
        waited = 0;
        #1;
        while (!in_ready) begin
            @(negedge clk);
            waited++;
            if (waited > 200) begin
                check("accept_timeout", {31'b0, in_ready}, 32'd1);
                in_valid = 1'b0;
                return;
            end
            #1;
        end
        m = model_enc(r);
        if (m[32]) begin
            err_acc++;
            if (err_exp < 255) err_exp++;
        end else begin
            exp_q.push_back(m[31:0]);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        rand_mode = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        #3;
        $display("section %s: emitted=%0d dropped=%0d", tag, hs_cnt, pulse_cnt);
        check({tag, "_queue_left"}, exp_q.size(), 32'd0);
        check({tag, "_inst_count"}, 32'(inst_count), hs_cnt);
        check({tag, "_err_count"}, 32'(err_count), err_exp);
        check({tag, "_err_pulses"}, pulse_cnt, err_acc);
        @(negedge clk);
    endtask

    function automatic req_t mk(input logic [1:0] c, input logic [2:0] d, input logic [3:0] cd,
                                input logic [3:0] o, input logic s, input logic [3:0] rn,
                                input logic [3:0] rd, input logic [11:0] op2, input logic [25:0] raw);
        req_t r;
        r.cls = c; r.dt = d; r.cond = cd; r.opc = o; r.s = s;
        r.rn = rn; r.rd = rd; r.op2 = op2; r.raw = raw;
        return r;
    endfunction

    // Output monitor: scores every handshake and checks hold-while-stalled.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_inst = '0;
    initial forever begin
        logic [31:0] w;
        @(negedge clk);
        #2;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'b0, out_valid}, 32'd1);
                check("hold_inst", out_inst, prev_inst);
            end
            if (err_pulse) pulse_cnt++;
            if (out_valid && out_ready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("spurious_word", {31'b0, out_valid}, 32'd0);
                end else begin
                    w = exp_q.pop_front();
                    check("word", out_inst, w);
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_inst  = out_inst;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        int c0;
        int p0, h0;
        req_t r;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_out_inst", out_inst, 32'd0);
        check("rst_err_pulse", {31'b0, err_pulse}, 32'd0);
        check("rst_inst_count", 32'(inst_count), 32'd0);
        check("rst_err_count", 32'(err_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #3;
        check("post_rst_in_ready", {31'b0, in_ready}, 32'd1);

        // dtype1 with latency check
        @(negedge clk);
        send(mk(2'd1, 3'd1, 4'hE, 4'd4, 1'b0, 4'd1, 4'd2, 12'h0FF, 26'h0));
        #3;
        check("lat_stage_a", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        #3;
        check("lat_stage_b", {31'b0, out_valid}, 32'd1);
        check("dp_imm_word", out_inst, 32'hE28120FF);
        drain("dp_imm");
        check("dp_imm_count1", 32'(inst_count), 32'd1);

        send(mk(2'd1, 3'd4, 4'hE, 4'd1, 1'b1, 4'd3, 4'd4, 12'h506, 26'h0));
        @(negedge clk);
        #3;
        check("mul_word", out_inst, 32'hE0334596);
        drain("mul");

        // back-to-back non-DP classes
        c0 = cyc;
        send(mk(2'd2, 3'd0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h1234567));
        send(mk(2'd3, 3'd0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h1234567));
        send(mk(2'd0, 3'd0, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h1234567));
        check("b2b_accept_cycles", cyc - c0, 32'd3);
        #3;
        check("b2b_valid0", {31'b0, out_valid}, 32'd1);
        @(negedge clk);
        #3;
        check("b2b_valid1", {31'b0, out_valid}, 32'd1);
        check("b2b_last_word", out_inst, 32'hED234567);
        @(negedge clk);
        #3;
        check("b2b_valid_end", {31'b0, out_valid}, 32'd0);
        drain("b2b");

        // backpressure: out_ready low for 4 cycles, 3 requests offered
        out_ready = 1'b0;
        fork
            begin repeat (4) @(negedge clk); out_ready = 1'b1; end
        join_none
        send(mk(2'd1, 3'd2, 4'h1, 4'd13, 1'b1, 4'd5, 4'd6, 12'hABC, 26'h0));
        send(mk(2'd1, 3'd3, 4'h2, 4'd2, 1'b0, 4'd7, 4'd8, 12'h3D5, 26'h0));
        in_valid = 1'b1;
        #1;
        check("stall_in_ready", {31'b0, in_ready}, 32'd0);
        send(mk(2'd3, 3'd0, 4'h0, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h3FFFFFF));
        drain("stall");

        // illegal between two legal requests
        p0 = pulse_cnt; h0 = hs_cnt;
        send(mk(2'd1, 3'd1, 4'hA, 4'd9, 1'b1, 4'd2, 4'd3, 12'h123, 26'h0));
        send(mk(2'd1, 3'd6, 4'hA, 4'd9, 1'b1, 4'd2, 4'd3, 12'h123, 26'h0));
        send(mk(2'd2, 3'd6, 4'hB, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h0ABCDEF));
        drain("illegal");
        check("illegal_pulses", pulse_cnt - p0, 32'd1);
        check("illegal_emitted", hs_cnt - h0, 32'd2);
        check("illegal_err_count", 32'(err_count), 32'd1);

        // drive err_count into saturation
        for (int i = 0; i < 260; i++)
            send(mk(2'd1, (i % 2 == 0) ? 3'd0 : 3'd7, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h0));
        drain("err_sat");
        check("err_sat_value", 32'(err_count), 32'd255);
        send(mk(2'd1, 3'd5, 4'hE, 4'd0, 1'b0, 4'd0, 4'd0, 12'h0, 26'h0));
        drain("err_sat2");
        check("err_sat_hold", 32'(err_count), 32'd255);

        // randomized traffic with random backpressure
        rand_mode = 1'b1;
        for (int i = 0; i < 300; i++) begin
            r.cls = 2'($urandom_range(0, 3));
            r.dt  = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(1, 4));
            r.cond = 4'($urandom); r.opc = 4'($urandom); r.s = 1'($urandom);
            r.rn = 4'($urandom); r.rd = 4'($urandom);
            r.op2 = 12'($urandom); r.raw = 26'($urandom);
            send(r);
            if ($urandom_range(0, 4) == 0) @(negedge clk);
        end
        drain("random");

        // asynchronous reset with both stages full
        out_ready = 1'b0;
        send(mk(2'd1, 3'd1, 4'h3, 4'd1, 1'b0, 4'd1, 4'd1, 12'h001, 26'h0));
        send(mk(2'd1, 3'd1, 4'h3, 4'd2, 1'b0, 4'd2, 4'd2, 12'h002, 26'h0));
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("async_rst_inst_count", 32'(inst_count), 32'd0);
        check("async_rst_err_count", 32'(err_count), 32'd0);
        exp_q.delete();
        hs_cnt = 0; pulse_cnt = 0; err_acc = 0; err_exp = 0;
        @(negedge clk);
        #3;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        #3;
        check("after_rst_in_ready", {31'b0, in_ready}, 32'd1);
        check("after_rst_out_valid", {31'b0, out_valid}, 32'd0);
        drain("after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=done", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/arm_inst_encoder.md
Name: arm_inst_encoder

Overview:
- Builds 32-bit ARM instruction words from a field bundle. It is the encoding counterpart of the team's instruction-class decoder.
- Feeds generated instruction streams into the decoder and datapath benches, and into the instruction-memory preload path.
- Two-stage valid/ready pipeline. Illegal requests are dropped and flagged. Saturating counters track emitted and rejected requests.

Parameters:
- CNT_W, 16, width of emitted-instruction counter
- ERR_W, 8, width of rejected-request counter

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept request
- in_class  in  2  0=coprocessor/SWI, 1=data processing, 2=load/store, 3=branch
- in_dtype  in  3  data-proc subtype: 1=immediate, 2=reg shift-by-imm, 3=reg shift-by-reg, 4=multiply
- in_cond  in  4  condition field, bits[31:28]
- in_opcode  in  4  DP opcode; for multiply, bit0 = A (accumulate)
- in_s  in  1  S bit
- in_rn  in  4  Rn (multiply: Rd, placed at [19:16])
- in_rd  in  4  Rd (multiply: Rn, placed at [15:12])
- in_op2  in  12  operand-2 field bundle
- in_raw  in  26  bits[25:0] for classes 0, 2, 3
- out_valid  out  1  encoded word valid
- out_ready  in  1  consumer accepts word
- out_inst  out  32  encoded instruction
- err_pulse  out  1  one-cycle pulse, illegal request dropped
- inst_count  out  CNT_W  emitted words, saturating
- err_count  out  ERR_W  dropped requests, saturating

Behaviour:
- Reset (asynchronous, rst_n low): all of the following clear to 0: out_valid, out_inst, err_pulse, inst_count, err_count, and both stage-valid flags. in_ready is 1 from the first cycle after reset is released. Reset mid-transfer discards all in-flight requests; nothing is emitted.
- Stage A captures the request when in_valid && in_ready. Stage B holds the encoded word on out_inst/out_valid.
- Ready logic:
  - b_ready = !out_valid || out_ready
  - in_ready = !a_valid || b_ready
- Latency: accepted in cycle N → out_valid in cycle N+1 when unstalled. Throughput is one word per cycle with out_ready held high.
- out_inst and out_valid hold stable while out_valid && !out_ready.
- Encoding, class 1 (bits[27:26]=00):
  - dtype1: {cond,00,1,opcode,S,rn,rd,op2[11:0]}
  - dtype2: {cond,00,0,opcode,S,rn,rd,op2[11:7],op2[6:5],0,op2[3:0]}
  - dtype3: {cond,00,0,opcode,S,rn,rd,op2[11:8],0,op2[6:5],1,op2[3:0]}
  - dtype4: {cond,000000,opcode[0],S,rn,rd,op2[11:8],1001,op2[3:0]}; bit24=0, bits[7:4]=1001 forced
- Encoding, classes 0/2/3: {cond, bits[27:26], in_raw[25:0]}, where bits[27:26] = 11 for class 0, 01 for class 2, 10 for class 3.
- Illegal request: class 1 with dtype 0 or 5–7.
  - Stage B does not set out_valid.
  - err_pulse is high for exactly the one cycle the request leaves stage A.
  - err_count increments.
  - A legal request behind it proceeds without a bubble.
- inst_count increments on each out_valid && out_ready.
- Both counters saturate at all-ones and never wrap.
- An illegal request sitting in stage A while stage B is stalled waits; its err_pulse fires only when it advances.

Test Plan:
- Reset, then class1/dtype1, cond=E, opcode=4, S=0, rn=1, rd=2, op2=0x0FF → out_inst=0xE28120FF one cycle after accept; inst_count=1.
- class1/dtype4, cond=E, opcode[0]=1, S=1, rn=3, rd=4, op2={Rs=5,-,Rm=6} → out_inst=0xE0334596; bit24=0, bits[7:4]=1001.
- Back-to-back class 2, 3, 0 with in_raw=0x1234567, cond=E → 0xE5234567, 0xE9234567, 0xED234567, one per cycle, no bubbles.
- out_ready held low 4 cycles with 3 requests offered → in_ready drops after 2 accepted; out_inst stable; all 3 emitted in order once out_ready rises.
- class1/dtype6 between two legal requests → single err_pulse, err_count=1, only 2 words emitted; force err_count to 0xFF, repeat → stays 0xFF.
- rst_n asserted with both stages full → out_valid=0 immediately; after release no stale word appears.
